// File: rtl/interp_sched_if.sv
// Bus between the interpolator scheduler, its sample source, the interpolator and the output sink.
// INTERP_SCHED_STATS_EN adds the out_cnt/replay_cnt/stall_cnt statistics signals.
interface interp_sched_if #(
   parameter int DATA_WIDTH = 19,
   parameter int MU_FRAC    = 16
);
   logic                  en;
   logic [MU_FRAC:0]      cfg_step;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic [DATA_WIDTH-1:0] intp_data;
   logic [DATA_WIDTH-1:0] intp_mu;
   logic [DATA_WIDTH-1:0] intp_out;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  stall;
`ifdef INTERP_SCHED_STATS_EN
   logic [15:0]           out_cnt;
   logic [15:0]           replay_cnt;
   logic [15:0]           stall_cnt;

   modport master (
      output en, cfg_step, s_valid, s_data, intp_out,
      input  s_ready, intp_data, intp_mu, m_valid, m_data, stall,
      input  out_cnt, replay_cnt, stall_cnt
   );
   modport slave (
      input  en, cfg_step, s_valid, s_data, intp_out,
      output s_ready, intp_data, intp_mu, m_valid, m_data, stall,
      output out_cnt, replay_cnt, stall_cnt
   );
`else
   modport master (
      output en, cfg_step, s_valid, s_data, intp_out,
      input  s_ready, intp_data, intp_mu, m_valid, m_data, stall
   );
   modport slave (
      input  en, cfg_step, s_valid, s_data, intp_out,
      output s_ready, intp_data, intp_mu, m_valid, m_data, stall
   );
`endif
endinterface

// File: rtl/interp_sched.sv
// Sample-rate scheduler for the float cubic interpolator: NCO window/mu decisions and tap-slot sequencing.
// Optional statistics counters are enabled with INTERP_SCHED_STATS_EN.
//
// state  | meaning
// IDLE   | disabled, waiting for en
// PRIME  | filling the 4-sample history, no output
// DECIDE | waiting for a needed sample (after PRIME or a source gap)
// SLOT1  | coherent advance: one slot presenting the newest sample
// REPLAY | four slots re-presenting the whole window to rebuild the delay line
module interp_sched #(
   parameter int DATA_WIDTH = 19,
   parameter int MU_FRAC    = 16,
   parameter int SLOT_LEN   = 9,
   parameter int OUT_LAT    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   interp_sched_if.slave    bus
);
   localparam int SCW  = $clog2(SLOT_LEN);
   localparam int MANT = DATA_WIDTH - 9;
   localparam logic [MU_FRAC:0] ONE = {1'b1, {MU_FRAC{1'b0}}};

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PRIME  = 3'd1;
   localparam logic [2:0] S_DECIDE = 3'd2;
   localparam logic [2:0] S_SLOT1  = 3'd3;
   localparam logic [2:0] S_REPLAY = 3'd4;

   logic [2:0]            state;
   logic [SCW-1:0]        slot_cyc;
   logic [1:0]            rep_idx;
   logic [1:0]            prime_cnt;
   logic [MU_FRAC:0]      acc;
   logic                  coherent;
   logic [DATA_WIDTH-1:0] hist [4];

   logic [DATA_WIDTH-1:0] intp_data_r, intp_mu_r, m_data_r;
   logic                  m_valid_r, stall_r;

   logic [MU_FRAC:0]      step_sat, acc_base, acc_dec;
   logic                  out_slot, slot_last, cap, decide_pt, need, s_ready_c, hs;
   logic                  adv, coh_eff, wait_now, stall_set, go_slot1, go_replay;
   logic [DATA_WIDTH-1:0] hist_sh [4];

   // Float rendering of the NCO fraction: normalise on the leading one, truncate the mantissa.
   function automatic logic [DATA_WIDTH-1:0] mu_conv(input logic [MU_FRAC-1:0] f);
      logic [MU_FRAC-1:0] norm;
      logic [7:0]         e;
      int                 p;
      p = 0;
      for (int i = 0; i < MU_FRAC; i++)
         if (f[i]) p = i;
      norm = f << (MU_FRAC - 1 - p);
      e    = 8'(127 - MU_FRAC + p);
      mu_conv = (f == '0) ? '0 : {1'b0, e, norm[MU_FRAC-2 -: MANT]};
   endfunction

   always_comb begin
      step_sat  = (bus.cfg_step > ONE) ? ONE : bus.cfg_step;
      out_slot  = (state == S_SLOT1) || ((state == S_REPLAY) && (rep_idx == 2'd3));
      slot_last = (slot_cyc == SCW'(SLOT_LEN - 1));
      cap       = bus.en && out_slot && (slot_cyc == SCW'(OUT_LAT));
      decide_pt = bus.en && ((state == S_DECIDE) || (out_slot && slot_last));
      // In the output slot the step is applied combinationally so the decision sees the new phase.
      acc_base  = (state == S_DECIDE) ? acc : acc + step_sat;
      need      = acc_base[MU_FRAC];
      s_ready_c = bus.en && ((state == S_PRIME) || (decide_pt && need));
      hs        = bus.s_valid && s_ready_c;
      adv       = need && hs;
      acc_dec   = adv ? acc_base - ONE : acc_base;
      // Capture in the output slot has happened by its last cycle, even when OUT_LAT is that cycle.
      coh_eff   = out_slot || coherent;
      wait_now  = decide_pt && need && !bus.s_valid;
      stall_set = wait_now && (state != S_DECIDE);
      go_slot1  = decide_pt && !wait_now && coh_eff && adv;
      go_replay = decide_pt && !wait_now && !(coh_eff && adv);
      hist_sh   = hist;
      if (hs) begin
         hist_sh[0] = hist[1];
         hist_sh[1] = hist[2];
         hist_sh[2] = hist[3];
         hist_sh[3] = bus.s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         slot_cyc    <= '0;
         rep_idx     <= '0;
         prime_cnt   <= '0;
         acc         <= '0;
         coherent    <= 1'b0;
         intp_data_r <= '0;
         intp_mu_r   <= '0;
         m_data_r    <= '0;
         m_valid_r   <= 1'b0;
         stall_r     <= 1'b0;
         for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else if (!bus.en) begin
         state     <= S_IDLE;
         slot_cyc  <= '0;
         rep_idx   <= '0;
         prime_cnt <= '0;
         acc       <= '0;
         coherent  <= 1'b0;
         m_valid_r <= 1'b0;
         stall_r   <= 1'b0;
      end else begin
         m_valid_r <= cap;
         stall_r   <= stall_set;
         hist      <= hist_sh;
         if (cap) begin
            m_data_r <= bus.intp_out;
            coherent <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               state     <= S_PRIME;
               prime_cnt <= '0;
            end
            S_PRIME: begin
               if (hs) begin
                  prime_cnt <= prime_cnt + 2'd1;
                  if (prime_cnt == 2'd3) begin
                     state    <= S_DECIDE;
                     acc      <= '0;
                     coherent <= 1'b0;
                  end
               end
            end
            default: begin
               if (wait_now) begin
                  state    <= S_DECIDE;
                  acc      <= acc_base;
                  coherent <= 1'b0;
               end else if (decide_pt) begin
                  acc       <= acc_dec;
                  intp_mu_r <= mu_conv(acc_dec[MU_FRAC-1:0]);
                  slot_cyc  <= '0;
                  rep_idx   <= '0;
                  if (go_slot1) begin
                     state       <= S_SLOT1;
                     intp_data_r <= hist_sh[3];
                  end else begin
                     state       <= S_REPLAY;
                     intp_data_r <= hist_sh[0];
                  end
               end else if (slot_last) begin
                  slot_cyc    <= '0;
                  rep_idx     <= rep_idx + 2'd1;
                  intp_data_r <= hist[rep_idx + 2'd1];
               end else begin
                  slot_cyc <= slot_cyc + SCW'(1);
               end
            end
         endcase
      end
   end

   assign bus.s_ready   = s_ready_c;
   assign bus.intp_data = intp_data_r;
   assign bus.intp_mu   = intp_mu_r;
   assign bus.m_valid   = m_valid_r;
   assign bus.m_data    = m_data_r;
   assign bus.stall     = stall_r;

`ifdef INTERP_SCHED_STATS_EN
   logic [15:0] out_cnt, replay_cnt, stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt    <= '0;
         replay_cnt <= '0;
         stall_cnt  <= '0;
      end else if (!bus.en) begin
         out_cnt    <= '0;
         replay_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (m_valid_r && (out_cnt != 16'hFFFF))    out_cnt    <= out_cnt + 16'd1;
         if (go_replay && (replay_cnt != 16'hFFFF)) replay_cnt <= replay_cnt + 16'd1;
         if (stall_r && (stall_cnt != 16'hFFFF))    stall_cnt  <= stall_cnt + 16'd1;
      end
   end

   assign bus.out_cnt    = out_cnt;
   assign bus.replay_cnt = replay_cnt;
   assign bus.stall_cnt  = stall_cnt;
`endif
endmodule

// File: tb/tb_interp_sched.sv
// Randomized bench for interp_sched against a transaction-level NCO/window model.
// A stand-in interpolator returns intp_data ^ intp_mu so m_data exposes both the last tap and mu.
module tb_interp_sched;
   localparam int DW = 19;
   localparam int MF = 16;
   localparam int SL = 9;
   localparam int OL = 8;
   localparam int G0 = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   interp_sched_if #(.DATA_WIDTH(DW), .MU_FRAC(MF)) bus ();

   interp_sched #(.DATA_WIDTH(DW), .MU_FRAC(MF), .SLOT_LEN(SL), .OUT_LAT(OL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.intp_out = bus.intp_data ^ bus.intp_mu;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] xs[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference mu: fraction as a real, repacked from the IEEE double into 1/8/10 float.
   function automatic logic [DW-1:0] mu_ref(input int a);
      real         r;
      logic [63:0] b;
      int          e;
      if (a == 0) return '0;
      r = real'(a) / 65536.0;
      b = $realtobits(r);
      e = int'(b[62:52]) - 1023 + 127;
      return {1'b0, e[7:0], b[51:42]};
   endfunction

   task automatic run_seg(input logic [MF:0] step, input int n_out, input bit late, input int seg);
      logic [DW-1:0] exp_m[$];
      bit            exp_rep[$];
      logic [DW-1:0] taps[$];
      logic [DW-1:0] last_tap, exp_tap;
      int  stp, acc, b, b_next, late_k, idx, gap;
      int  hs_n, h4, hsg, outs, last_mv, stalls, t, budget;
      bit  adv, rep, hs, waiting;

      xs.delete();
      for (int i = 0; i < n_out + 12; i++)
         xs.push_back({3'($urandom), 4'(seg), 12'(i + 1)});

      stp = (int'(step) > 65536) ? 65536 : int'(step);
      acc = 0; b = 0; b_next = 0; late_k = -1;
      for (int k = 0; k <= n_out; k++) begin
         adv = 1'b0;
         if (k > 0) begin
            acc += stp;
            if (acc >= 65536) begin
               acc -= 65536;
               b++;
               adv = 1'b1;
            end
         end
         rep = (k == 0) || !adv || (late && adv && (b + 3 == G0));
         if (late && adv && (b + 3 == G0)) late_k = k;
         if (k < n_out) begin
            exp_m.push_back(xs[b+3] ^ mu_ref(acc));
            exp_rep.push_back(rep);
         end else begin
            b_next = b;
         end
         if (rep) for (int j = 0; j < 4; j++) taps.push_back(xs[b+j]);
         else taps.push_back(xs[b+3]);
      end

      idx = 0; gap = 0;
      bus.cfg_step = step;
      bus.s_data   = xs[0];
      bus.s_valid  = 1'b1;
      bus.en       = 1'b1;
      hs_n = 0; h4 = -1000; hsg = -1000; outs = 0; last_mv = 0; stalls = 0; t = 0;
      waiting = 1'b0;
      last_tap = bus.intp_data;
      budget = n_out * 40 + 120;

      while (outs < n_out && t < budget) begin
         @(negedge clk);
         t++;
         hs = bus.s_valid && bus.s_ready;
         if (bus.intp_data !== last_tap) begin
            last_tap = bus.intp_data;
            exp_tap  = (taps.size() > 0) ? taps.pop_front() : '1;
            chk("tap", bus.intp_data, exp_tap);
         end
         if (bus.m_valid) begin
            chk("m_data", bus.m_data, exp_m[outs]);
            chk("mv_in_gap", 32'(waiting), 0);
            if (outs == 0)
               chk("first_lat", t - h4, 3*SL + OL + 3);
            else if (outs == late_k)
               chk("stall_lat", t - hsg, 4*SL + 1);
            else
               chk("interval", t - last_mv, exp_rep[outs] ? 4*SL : SL);
            last_mv = t;
            outs++;
         end
         if (bus.stall) begin
            stalls++;
            waiting = 1'b1;
         end
         if (hs) begin
            hs_n++;
            if (hs_n == 4) h4 = t;
            if (late && idx == G0) hsg = t;
            waiting = 1'b0;
         end
         @(posedge clk);
         #1;
         if (hs) idx++;
         bus.s_data = xs[idx];
         if (late && hs && idx == G0) gap = 20;
         bus.s_valid = (gap == 0);
         if (gap > 0) gap--;
      end
      chk("outputs", outs, n_out);
      chk("stalls", stalls, late ? 1 : 0);
      chk("consumed", hs_n, b_next + 4);

      bus.en = 1'b0;
      @(negedge clk);
      chk("ready_en0", 32'(bus.s_ready), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_s_ready"},   32'(bus.s_ready), 0);
      chk({tag, "_intp_data"}, bus.intp_data, 0);
      chk({tag, "_intp_mu"},   bus.intp_mu, 0);
      chk({tag, "_m_valid"},   32'(bus.m_valid), 0);
      chk({tag, "_m_data"},    bus.m_data, 0);
      chk({tag, "_stall"},     32'(bus.stall), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hs;
      int idx;
      bus.en = 1'b0;
      bus.cfg_step = '0;
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_seg(17'h10000, 12, 1'b0, 1);
      run_seg(17'h08000, 10, 1'b0, 2);
      run_seg(17'h04000, 10, 1'b0, 3);
      run_seg(17'h10000, 12, 1'b1, 4);
      run_seg(17'h18000, 10, 1'b0, 5);
      run_seg(17'h00000, 4,  1'b0, 6);
      for (int s = 7; s < 10; s++)
         run_seg(17'($urandom_range(1, 65536)), 10, 1'b0, s);

      // Start a stream and pull reset while the first REPLAY is in progress.
      xs.delete();
      for (int i = 0; i < 8; i++) xs.push_back({3'($urandom), 4'(10), 12'(i + 1)});
      idx = 0;
      bus.cfg_step = 17'h08000;
      bus.s_data = xs[0];
      bus.s_valid = 1'b1;
      bus.en = 1'b1;
      repeat (25) begin
         @(negedge clk);
         hs = bus.s_valid && bus.s_ready;
         @(posedge clk);
         #1;
         if (hs) idx++;
         bus.s_data = xs[idx];
      end
      chk("pre_reset_busy", 32'(bus.intp_data != '0), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_seg(17'h08000, 6, 1'b0, 11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
